sram_cache_ctrl: RTL and testbench
==================================

// Module: sram_cache_ctrl
// PURPOSE
//  Initiator side of the tag/data SRAM array interface: a direct-mapped, 1-byte-line cache controller.
//  - Decodes the request index into the one-hot wordline the array requires.
//  - Drives write enable and tag/data into the array, compares the returned tag, tracks per-line valid bits.
//  - Services misses and write-through stores over a simple memory req/ack port.
//  - Sits between the CPU load/store port and the SRAM array plus backing memory.
// PARAMETERS
//  TAG_W   4   tag width; matches array tag width; addr[ADDR_W-1:IDX_W]
//  IDX_W   4   index width; wordline width = 2**IDX_W (16); addr[IDX_W-1:0]
//  DATA_W  8   data width per line
//  CNT_W   8   width of saturating hit/miss counters
// PORTS
//  clk            in   1         clock; all state changes on posedge
//  reset          in   1         asynchronous, active-high reset
//  req_valid      in   1         CPU request valid
//  req_ready      out  1         controller can accept (state IDLE)
//  req_we         in   1         1=store, 0=load
//  req_addr       in   TAG_W+IDX_W  {tag,index}
//  req_wdata      in   DATA_W    store data
//  resp_valid     out  1         one-cycle response pulse, no backpressure
//  resp_rdata     out  DATA_W    load data (store: echoes req_wdata)
//  resp_hit       out  1         request hit (tag match and valid)
//  sram_we        out  1         array write enable (written at posedge)
//  sram_wl        out  2**IDX_W  one-hot wordline
//  sram_tag_in    out  TAG_W     tag to array
//  sram_data_in   out  DATA_W    data to array
//  sram_tag_out   in   TAG_W     array tag read (combinational, bypasses tag_in when we=1)
//  sram_data_out  in   DATA_W    array data read (same timing)
//  mem_req        out  1         backing-memory request, held until mem_ack
//  mem_we         out  1         1=write-through store, 0=line fetch
//  mem_addr       out  TAG_W+IDX_W  latched request address
//  mem_wdata      out  DATA_W    latched store data
//  mem_ack        in   1         one-cycle completion; mem_rdata valid same cycle
//  mem_rdata      in   DATA_W    fetched data
//  hit_cnt        out  CNT_W     saturating hit count
//  miss_cnt       out  CNT_W     saturating miss count
// BEHAVIOUR
//  Reset (async, immediate)
//   - state=IDLE; valid[] cleared; latched addr/wdata/fill=0; counters=0.
//   - All outputs 0 except req_ready=1 and sram_wl=1 (index 0).
//  Wordline
//   - sram_wl is always one-hot of the latched index; never all-zero, never multi-hot.
//  Accept
//   - In IDLE, req_valid&req_ready at posedge latches addr, we, wdata.
//   - Next state is LOOKUP, or MEM if req_we=1.
//  LOOKUP (loads only)
//   - sram_we=0; hit = valid[idx] && sram_tag_out==tag.
//   - hit: capture sram_data_out -> RESP, resp_hit=1, hit_cnt++.
//   - miss: -> MEM (mem_we=0), miss_cnt++.
//  MEM
//   - mem_req=1; mem_addr/mem_we/mem_wdata stable until mem_ack.
//   - On mem_ack, fill=mem_rdata (load) or wdata (store) -> FILL.
//  Stores: write-through, write-allocate
//   - Counted as miss (resp_hit=0) unless valid[idx] && tag matched at accept.
//   - That tag check happens in MEM's first cycle with sram_we=0.
//  FILL
//   - Exactly one cycle with sram_we=1, sram_tag_in=tag, sram_data_in=fill.
//   - valid[idx] set at the same posedge -> RESP.
//  RESP
//   - resp_valid=1 for one cycle, resp_rdata=fill/hit data -> IDLE.
//   - req_ready=0 in every state except IDLE.
//  Latency (accept edge = N)
//   - Load hit: resp_valid in cycle after N+1.
//   - Load miss: resp in cycle after mem_ack edge + 2.
//   - Store: same as load miss.
//  Boundaries
//   - Counters saturate at all-ones, no wrap.
//   - mem_ack outside MEM is ignored.
//   - req_valid while busy is ignored (not queued).
//   - Same index, different tag: load misses and replaces the line.
//   - Reset mid-MEM/FILL drops mem_req at once; no resp; no valid set.
// TESTING
//  1. Reset, load 0x35 -> miss; mem_req=1, mem_addr=0x35; ack rdata=0xA7 -> wl=0x0020, we=1, tag 3; resp 0xA7, hit=0.
//  2. Load 0x35 again -> resp_hit=1, rdata=0xA7, resp_valid 2 cycles after accept, no mem_req; hit_cnt=1.
//  3. Load 0x45 (same idx 5, tag 4) -> miss, refill 0x11; then load 0x35 -> miss (evicted).
//  4. Store 0xF0 data 0x5C -> mem_req, mem_we=1, wdata=0x5C; after ack load 0xF0 hits with 0x5C, wl=0x0001.
//  5. Assert reset while mem_req=1 -> mem_req, resp_valid low same cycle; load 0xF0 afterwards misses.
//  6. 300 hits to one address -> hit_cnt saturates at 0xFF; req_valid held during busy accepted only in IDLE.

Source files
------------

// File: rtl/sram_cache_ctrl.sv
// Direct-mapped 1-byte-line cache controller: drives a tag/data SRAM array and a backing-memory port.
// Latency: load hit -> resp two cycles after accept; miss/store -> resp two cycles after mem_ack.
// Backpressure: req_ready only in IDLE (busy requests ignored); mem_req held until mem_ack; resp has none.
//
// Ports: clk/reset; CPU side req_valid/req_ready/req_we/req_addr/req_wdata and resp_valid/resp_rdata/resp_hit;
//        array side sram_we/sram_wl/sram_tag_in/sram_data_in (out), sram_tag_out/sram_data_out (in);
//        memory side mem_req/mem_we/mem_addr/mem_wdata (out), mem_ack/mem_rdata (in);
//        hit_cnt/miss_cnt saturating statistics.
module sram_cache_ctrl #(
    parameter int TAG_W  = 4,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [TAG_W+IDX_W-1:0] req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_hit,
    output logic                   sram_we,
    output logic [(1<<IDX_W)-1:0]  sram_wl,
    output logic [TAG_W-1:0]       sram_tag_in,
    output logic [DATA_W-1:0]      sram_data_in,
    input  logic [TAG_W-1:0]       sram_tag_out,
    input  logic [DATA_W-1:0]      sram_data_out,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt
);
    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int LINES  = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM,
        S_FILL,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_fill;
    logic                r_hit;
    logic                r_mem_first;   // first MEM cycle of a store: tag check slot
    logic [LINES-1:0]    r_valid;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_tag_hit;
    logic                w_inc_hit;
    logic                w_inc_miss;
    logic [LINES-1:0]    w_wl_one;

    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_tag     = r_addr[ADDR_W-1:IDX_W];
    assign w_tag_hit = r_valid[w_idx] && (sram_tag_out == w_tag);
    assign w_wl_one  = {{(LINES-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, counter strobes and all array/memory/response outputs.
    always_comb begin
        w_next       = r_state;
        w_inc_hit    = 1'b0;
        w_inc_miss   = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_hit     = 1'b0;
        sram_we      = 1'b0;
        sram_tag_in  = '0;
        sram_data_in = '0;
        mem_req      = 1'b0;
        // Wordline follows the latched index, so it is one-hot even in reset.
        sram_wl      = w_wl_one << w_idx;
        mem_we       = r_we;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        resp_rdata   = r_fill;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_we ? S_MEM : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_tag_hit) begin
                    w_next    = S_RESP;
                    w_inc_hit = 1'b1;
                end else begin
                    w_next     = S_MEM;
                    w_inc_miss = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (r_mem_first) begin
                    w_inc_hit  = w_tag_hit;
                    w_inc_miss = !w_tag_hit;
                end
                if (mem_ack) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                sram_we      = 1'b1;
                sram_tag_in  = w_tag;
                sram_data_in = r_fill;
                w_next       = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = r_hit;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_fill      <= '0;
            r_hit       <= 1'b0;
            r_mem_first <= 1'b0;
            r_valid     <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_we        <= req_we;
                        r_wdata     <= req_wdata;
                        r_mem_first <= req_we;
                        r_hit       <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (w_tag_hit) begin
                        r_fill <= sram_data_out;
                        r_hit  <= 1'b1;
                    end
                end
                S_MEM: begin
                    r_mem_first <= 1'b0;
                    if (r_mem_first) begin
                        r_hit <= w_tag_hit;
                    end
                    if (mem_ack) begin
                        r_fill <= r_we ? r_wdata : mem_rdata;
                    end
                end
                S_FILL: begin
                    r_valid[w_idx] <= 1'b1;
                end
                default: ;
            endcase
            if (w_inc_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_inc_miss && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// Bench for sram_cache_ctrl with a behavioural tag/data array and a directed memory responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_wdata = 8'h00;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_hit;
    logic        sram_we;
    logic [15:0] sram_wl;
    logic [3:0]  sram_tag_in;
    logic [7:0]  sram_data_in;
    logic [3:0]  sram_tag_out;
    logic [7:0]  sram_data_out;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  hit_cnt;
    logic [7:0]  miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .sram_we(sram_we), .sram_wl(sram_wl), .sram_tag_in(sram_tag_in),
        .sram_data_in(sram_data_in), .sram_tag_out(sram_tag_out), .sram_data_out(sram_data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Behavioural SRAM array: combinational read of the selected line, write-through bypass when we=1.
    logic [3:0] arr_tag [16];
    logic [7:0] arr_dat [16];
    int         wl_idx;
    always_comb begin
        wl_idx = 0;
        for (int i = 0; i < 16; i++) if (sram_wl[i]) wl_idx = i;
    end
    assign sram_tag_out  = sram_we ? sram_tag_in  : arr_tag[wl_idx];
    assign sram_data_out = sram_we ? sram_data_in : arr_dat[wl_idx];
    always @(posedge clk) begin
        if (sram_we) begin
            arr_tag[wl_idx] <= sram_tag_in;
            arr_dat[wl_idx] <= sram_data_in;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] ack;
        logic       exp_hit;
        logic       exp_mem;
        logic [7:0] exp_rdata;
    } vec_t;

    // One full transaction: accept, serve memory if asked (ack two cycles into MEM), check fill and response.
    task automatic do_req(input vec_t v, input string nm);
        int         cyc;
        int         mem_cyc;
        int         ack_cyc;
        bit         saw_mem;
        bit         saw_fill;
        bit         done;
        logic [15:0] one;
        logic [15:0] exp_wl;
        one    = 16'h0001;
        exp_wl = one << v.addr[3:0];
        @(negedge clk);
        chk({nm, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0; mem_cyc = 0; ack_cyc = -10; saw_mem = 0; saw_fill = 0; done = 0;
        while (!done && cyc < 40) begin
            if (mem_req) begin
                if (!saw_mem) begin
                    saw_mem = 1; mem_cyc = cyc;
                end
                chk({nm, ".mem_addr"}, mem_addr, v.addr);
                chk({nm, ".mem_we"}, mem_we, v.we);
                if (v.we) chk({nm, ".mem_wdata"}, mem_wdata, v.wdata);
                if (cyc == mem_cyc + 2) begin
                    mem_ack = 1'b1; mem_rdata = v.ack; ack_cyc = cyc;
                end
            end
            if (sram_we) begin
                saw_fill = 1;
                chk({nm, ".fill_wl"}, sram_wl, exp_wl);
                chk({nm, ".fill_tag"}, sram_tag_in, v.addr[7:4]);
                chk({nm, ".fill_data"}, sram_data_in, v.exp_rdata);
                chk({nm, ".fill_lat"}, cyc, ack_cyc + 1);
            end
            if (resp_valid) begin
                done = 1;
                chk({nm, ".rdata"}, resp_rdata, v.exp_rdata);
                chk({nm, ".hit"}, resp_hit, v.exp_hit);
                chk({nm, ".resp_lat"}, cyc, v.exp_mem ? ack_cyc + 2 : 1);
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 8'h00;
            cyc++;
        end
        chk({nm, ".resp_seen"}, done, 1);
        chk({nm, ".mem_used"}, saw_mem, v.exp_mem);
        chk({nm, ".fill_used"}, saw_fill, v.exp_mem);
    endtask

    vec_t vecs [9];
    vec_t v;
    int   n;

    initial begin
        //            we    addr   wdata  ack    hit   mem   rdata
        vecs[0] = '{1'b0, 8'h35, 8'h00, 8'hA7, 1'b0, 1'b1, 8'hA7}; // cold miss
        vecs[1] = '{1'b0, 8'h35, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA7}; // hit
        vecs[2] = '{1'b0, 8'h45, 8'h00, 8'h11, 1'b0, 1'b1, 8'h11}; // same idx, new tag
        vecs[3] = '{1'b0, 8'h35, 8'h00, 8'hA7, 1'b0, 1'b1, 8'hA7}; // evicted
        vecs[4] = '{1'b1, 8'hF0, 8'h5C, 8'h00, 1'b0, 1'b1, 8'h5C}; // store miss, allocate
        vecs[5] = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5C}; // hit on stored line
        vecs[6] = '{1'b1, 8'hF0, 8'h77, 8'h00, 1'b1, 1'b1, 8'h77}; // store hit, still write-through
        vecs[7] = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h77};
        vecs[8] = '{1'b0, 8'h3A, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00}; // miss returning zero data

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", req_ready, 1);
        chk("rst.wl", sram_wl, 16'h0001);
        chk("rst.sram_we", sram_we, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.hit_cnt", hit_cnt, 0);
        chk("rst.miss_cnt", miss_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end
        chk("cnt.hit", hit_cnt, 8'd4);
        chk("cnt.miss", miss_cnt, 8'd5);

        // mem_ack while idle must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("stray_ack.ready", req_ready, 1);
        chk("stray_ack.sram_we", sram_we, 0);
        chk("stray_ack.resp", resp_valid, 0);
        v = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h77};
        do_req(v, "stray_ack.reload");

        // req_valid held while busy is neither accepted nor queued
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h67;
        @(negedge clk);
        req_addr = 8'h89;
        chk("busy.ready", req_ready, 0);
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("busy.mem_req", mem_req, 1);
        chk("busy.mem_addr", mem_addr, 8'h67);
        chk("busy.ready_mem", req_ready, 0);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        @(negedge clk);
        mem_ack = 1'b0; req_valid = 1'b0;
        chk("busy.fill", sram_we, 1);
        chk("busy.fill_wl", sram_wl, 16'h0080);
        @(negedge clk);
        chk("busy.resp", resp_valid, 1);
        chk("busy.rdata", resp_rdata, 8'h3C);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("busy.no_queue_mem", mem_req, 0);
            chk("busy.no_queue_resp", resp_valid, 0);
        end

        // Reset during MEM drops mem_req immediately and forgets valid lines
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h88; req_wdata = 8'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmem.mem_req_before", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rstmem.mem_req", mem_req, 0);
        chk("rstmem.resp", resp_valid, 0);
        chk("rstmem.ready", req_ready, 1);
        chk("rstmem.wl", sram_wl, 16'h0001);
        chk("rstmem.hit_cnt", hit_cnt, 0);
        chk("rstmem.miss_cnt", miss_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        v = '{1'b0, 8'hF0, 8'h00, 8'h42, 1'b0, 1'b1, 8'h42};
        do_req(v, "rstmem.load_f0");

        // Hit counter saturation
        v = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h42};
        for (int k = 0; k < 300; k++) begin
            do_req(v, "sat");
        end
        chk("sat.hit_cnt", hit_cnt, 8'hFF);
        chk("sat.miss_cnt", miss_cnt, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
